serial_input_receiver: RTL and testbench

//  Upstream stage of main_controller. Receives the MSDAP stereo serial stream (InputL/InputR, 16-bit, MSB first, framed by Frame on Dclk).
//  Re-times Dclk, Frame and data into the Sclk domain and deserialises each word.

---
 rtl/msdap_pkg.sv | 10 +
 rtl/zero_run_counter.sv | 52 +++++
 rtl/serial_input_receiver.sv | 183 ++++++++++++++++++
 tb/tb_serial_input_receiver.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/msdap_pkg.sv
// Shared defaults and types for the MSDAP serial front end.
package msdap_pkg;

  localparam int unsigned WORD_W   = 16;
  localparam int unsigned ZERO_RUN = 800;
  localparam int unsigned ZCNT_W   = 10;

  typedef enum logic {IDLE, SHIFT} rx_state_t;

endpackage

// File: rtl/zero_run_counter.sv
// Counts consecutive all-zero words on one channel; saturates at ZERO_RUN and raises flag_zero.
module zero_run_counter
  import msdap_pkg::*;
#(
  parameter int unsigned ZERO_RUN = msdap_pkg::ZERO_RUN,
  parameter int unsigned ZCNT_W   = msdap_pkg::ZCNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              word_done,
  input  logic              word_is_zero,
  output logic [ZCNT_W-1:0] zcnt,
  output logic              flag_zero
);

  localparam logic [ZCNT_W-1:0] RunMax = ZCNT_W'(ZERO_RUN);

  logic [ZCNT_W-1:0] zcnt_q, zcnt_d;
  logic              flag_q, flag_d;

  always_comb begin
    zcnt_d = zcnt_q;
    flag_d = flag_q;
    if (clr) begin
      zcnt_d = '0;
      flag_d = 1'b0;
    end else if (word_done) begin
      if (!word_is_zero) begin
        zcnt_d = '0;
      end else if (zcnt_q != RunMax) begin
        zcnt_d = zcnt_q + ZCNT_W'(1);
      end
      // Flag follows the updated count so it is valid alongside the word strobe.
      flag_d = (zcnt_d == RunMax);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zcnt_q <= '0;
      flag_q <= 1'b0;
    end else begin
      zcnt_q <= zcnt_d;
      flag_q <= flag_d;
    end
  end

  assign zcnt      = zcnt_q;
  assign flag_zero = flag_q;

endmodule

// File: rtl/serial_input_receiver.sv
// MSDAP serial receiver: re-times the Dclk-domain stereo stream into Sclk, deserialises
// each 16-bit word and tracks per-channel zero runs for the controller's sleep logic.
module serial_input_receiver
  import msdap_pkg::*;
#(
  parameter int unsigned WORD_W   = msdap_pkg::WORD_W,
  parameter int unsigned ZERO_RUN = msdap_pkg::ZERO_RUN,
  parameter int unsigned ZCNT_W   = msdap_pkg::ZCNT_W
) (
  input  logic              Sclk,
  input  logic              Reset_n,
  input  logic              Dclk,
  input  logic              Frame,
  input  logic              InputL,
  input  logic              InputR,
  input  logic              InReady,
  input  logic              Clear,
  output logic [WORD_W-1:0] dataL,
  output logic [WORD_W-1:0] dataR,
  output logic              in_flag,
  output logic              flag_zeroL,
  output logic              flag_zeroR,
  output logic              frame_err
);

  localparam int unsigned CNT_W = $clog2(WORD_W);

  logic [2:0]        dclk_sync_q;
  logic [1:0]        frame_sync_q, l_sync_q, r_sync_q;
  logic              dclk_rise;
  logic              tick_q, frame_q, bit_l_q, bit_r_q;
  rx_state_t         state_q, state_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [WORD_W-1:0] shift_l_q, shift_l_d, shift_r_q, shift_r_d;
  logic [WORD_W-1:0] data_l_d, data_r_d;
  logic              done_q, done_d;
  logic              in_flag_d, frame_err_d;
  logic              start;
  logic [ZCNT_W-1:0] unused_zcnt_l, unused_zcnt_r;

  assign dclk_rise = dclk_sync_q[1] & ~dclk_sync_q[2];

  // All serial inputs share one synchroniser depth, plus a one-cycle sample stage on the tick.
  always_ff @(posedge Sclk or negedge Reset_n) begin
    if (!Reset_n) begin
      dclk_sync_q  <= '0;
      frame_sync_q <= '0;
      l_sync_q     <= '0;
      r_sync_q     <= '0;
      tick_q       <= 1'b0;
      frame_q      <= 1'b0;
      bit_l_q      <= 1'b0;
      bit_r_q      <= 1'b0;
    end else begin
      dclk_sync_q  <= {dclk_sync_q[1:0], Dclk};
      frame_sync_q <= {frame_sync_q[0], Frame};
      l_sync_q     <= {l_sync_q[0], InputL};
      r_sync_q     <= {r_sync_q[0], InputR};
      tick_q       <= dclk_rise & ~Clear;
      frame_q      <= frame_sync_q[1];
      bit_l_q      <= l_sync_q[1];
      bit_r_q      <= r_sync_q[1];
    end
  end

  // A Frame mid-word restarts only if the controller is still accepting words.
  assign start = frame_q & InReady & ((state_q == IDLE) | (bit_cnt_q != '0));

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_l_d   = shift_l_q;
    shift_r_d   = shift_r_q;
    data_l_d    = dataL;
    data_r_d    = dataR;
    in_flag_d   = in_flag;
    done_d      = 1'b0;
    frame_err_d = 1'b0;
    if (Clear) begin
      state_d   = IDLE;
      bit_cnt_d = '0;
      shift_l_d = '0;
      shift_r_d = '0;
      data_l_d  = '0;
      data_r_d  = '0;
      in_flag_d = 1'b0;
    end else begin
      if (done_q) begin
        data_l_d  = shift_l_q;
        data_r_d  = shift_r_q;
        in_flag_d = 1'b1;
      end else if (tick_q) begin
        in_flag_d = 1'b0;
      end
      if (tick_q) begin
        case (state_q)
          IDLE: begin
            if (start) begin
              shift_l_d = WORD_W'(bit_l_q);
              shift_r_d = WORD_W'(bit_r_q);
              bit_cnt_d = CNT_W'(WORD_W - 2);
              state_d   = SHIFT;
            end
          end
          SHIFT: begin
            if (frame_q && bit_cnt_q != '0) begin
              frame_err_d = 1'b1;
              if (start) begin
                shift_l_d = WORD_W'(bit_l_q);
                shift_r_d = WORD_W'(bit_r_q);
                bit_cnt_d = CNT_W'(WORD_W - 2);
              end else begin
                bit_cnt_d = '0;
                state_d   = IDLE;
              end
            end else begin
              shift_l_d = {shift_l_q[WORD_W-2:0], bit_l_q};
              shift_r_d = {shift_r_q[WORD_W-2:0], bit_r_q};
              if (bit_cnt_q == '0) begin
                done_d  = 1'b1;
                state_d = IDLE;
              end else begin
                bit_cnt_d = bit_cnt_q - CNT_W'(1);
              end
            end
          end
          default: state_d = IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge Sclk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shift_l_q <= '0;
      shift_r_q <= '0;
      done_q    <= 1'b0;
      dataL     <= '0;
      dataR     <= '0;
      in_flag   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_l_q <= shift_l_d;
      shift_r_q <= shift_r_d;
      done_q    <= done_d;
      dataL     <= data_l_d;
      dataR     <= data_r_d;
      in_flag   <= in_flag_d;
      frame_err <= frame_err_d;
    end
  end

  zero_run_counter #(
    .ZERO_RUN(ZERO_RUN),
    .ZCNT_W  (ZCNT_W)
  ) u_zero_l (
    .clk         (Sclk),
    .rst_n       (Reset_n),
    .clr         (Clear),
    .word_done   (done_q),
    .word_is_zero(shift_l_q == '0),
    .zcnt        (unused_zcnt_l),
    .flag_zero   (flag_zeroL)
  );

  zero_run_counter #(
    .ZERO_RUN(ZERO_RUN),
    .ZCNT_W  (ZCNT_W)
  ) u_zero_r (
    .clk         (Sclk),
    .rst_n       (Reset_n),
    .clr         (Clear),
    .word_done   (done_q),
    .word_is_zero(shift_r_q == '0),
    .zcnt        (unused_zcnt_r),
    .flag_zero   (flag_zeroR)
  );

endmodule

// File: tb/tb_serial_input_receiver.sv
// Scoreboard bench for serial_input_receiver; zero-run threshold scaled down to keep runs short.
module tb_serial_input_receiver;

  localparam int unsigned ZR = 8;

  typedef struct {
    logic [15:0] l;
    logic [15:0] r;
    logic        fl;
    logic        fr;
  } exp_t;

  logic        Sclk = 1'b0;
  logic        Reset_n, Dclk, Frame, InputL, InputR, InReady, Clear;
  logic [15:0] dataL, dataR;
  logic        in_flag, flag_zeroL, flag_zeroR, frame_err;

  int   compared = 0;
  int   mismatched = 0;
  int   edge_cnt = 0;
  int   lsb_edge = 0;
  int   ferr_cycles = 0;
  int   dlow = 50;
  int   dhigh = 50;
  int   zl = 0;
  int   zr = 0;
  bit   flag_prev = 1'b0;
  exp_t exp_q[$];

  serial_input_receiver #(
    .WORD_W  (16),
    .ZERO_RUN(ZR),
    .ZCNT_W  (4)
  ) dut (
    .Sclk      (Sclk),
    .Reset_n   (Reset_n),
    .Dclk      (Dclk),
    .Frame     (Frame),
    .InputL    (InputL),
    .InputR    (InputR),
    .InReady   (InReady),
    .Clear     (Clear),
    .dataL     (dataL),
    .dataR     (dataR),
    .in_flag   (in_flag),
    .flag_zeroL(flag_zeroL),
    .flag_zeroR(flag_zeroR),
    .frame_err (frame_err)
  );

  always #5 Sclk = ~Sclk;
  always @(posedge Sclk) edge_cnt++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: one scoreboard entry per in_flag rising edge.
  always @(negedge Sclk) begin
    exp_t e;
    if (!Reset_n) begin
      flag_prev = 1'b0;
    end else begin
      if (in_flag && !flag_prev) begin
        if (exp_q.size() == 0) begin
          check("unexpected_word", 64'(dataL), 64'hdead);
        end else begin
          e = exp_q.pop_front();
          check("dataL", 64'(dataL), 64'(e.l));
          check("dataR", 64'(dataR), 64'(e.r));
          check("flag_zeroL", 64'(flag_zeroL), 64'(e.fl));
          check("flag_zeroR", 64'(flag_zeroR), 64'(e.fr));
          check("latency", 64'(edge_cnt - lsb_edge), 64'd4);
        end
      end
      flag_prev = in_flag;
      if (frame_err) ferr_cycles++;
    end
  end

  task automatic send_bit(input logic f, input logic l, input logic r);
    Frame = f; InputL = l; InputR = r; Dclk = 1'b0;
    #(dlow);
    Dclk = 1'b1;
    #(dhigh);
  endtask

  task automatic send_word(input logic [15:0] l, input logic [15:0] r, input bit expect_word,
                           input int drop_at);
    exp_t e;
    if (expect_word) begin
      zl = (l == 16'h0) ? ((zl < ZR) ? zl + 1 : ZR) : 0;
      zr = (r == 16'h0) ? ((zr < ZR) ? zr + 1 : ZR) : 0;
      e.l = l; e.r = r; e.fl = (zl == ZR); e.fr = (zr == ZR);
      exp_q.push_back(e);
    end
    for (int i = 15; i >= 0; i--) begin
      if (i == drop_at) InReady = 1'b0;
      Frame = (i == 15); InputL = l[i]; InputR = r[i]; Dclk = 1'b0;
      #(dlow);
      Dclk = 1'b1;
      if (i == 0) lsb_edge = edge_cnt + 1;
      #(dhigh);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int ferr_base;
    logic [15:0] wl, wr;
    Reset_n = 1'b0; Dclk = 1'b0; Frame = 1'b1; InputL = 1'b1; InputR = 1'b0;
    InReady = 1'b1; Clear = 1'b0;
    @(negedge Sclk);

    // 1: reset while the serial side is active
    for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b1, 1'b0);
    check("reset_outputs", 64'({dataL, dataR, in_flag, flag_zeroL, flag_zeroR, frame_err}), 64'd0);
    Reset_n = 1'b1;
    for (int i = 0; i < 20; i++) send_bit(1'b0, 1'b1, 1'b1);
    check("no_frame_no_word", 64'(in_flag), 64'd0);

    // 2: basic word, latency, in_flag drop on next tick
    ferr_base = ferr_cycles;
    send_word(16'hA5C3, 16'h0F0F, 1'b1, -1);
    check("in_flag_high", 64'(in_flag), 64'd1);
    send_bit(1'b0, 1'b0, 1'b0);
    check("in_flag_drop", 64'(in_flag), 64'd0);
    check("data_hold", 64'({dataL, dataR}), 64'hA5C30F0F);
    check("no_frame_err", 64'(ferr_cycles - ferr_base), 64'd0);

    // 3: zero run reaches threshold, then left channel wakes
    for (int i = 0; i < ZR - 1; i++) send_word(16'h0000, 16'h0000, 1'b1, -1);
    check("flags_below_run", 64'({flag_zeroL, flag_zeroR}), 64'd0);
    send_word(16'h0000, 16'h0000, 1'b1, -1);
    check("flags_at_run", 64'({flag_zeroL, flag_zeroR}), 64'd3);
    send_word(16'h0001, 16'h0000, 1'b1, -1);
    check("flags_after_wake", 64'({flag_zeroL, flag_zeroR}), 64'd1);

    // 4: Frame after 7 bits restarts the word
    ferr_base = ferr_cycles;
    send_bit(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) send_bit(1'b0, 1'b1, 1'b0);
    send_word(16'h8001, 16'h0000, 1'b1, -1);
    check("frame_err_pulse", 64'(ferr_cycles - ferr_base), 64'd1);
    check("restart_dataL", 64'(dataL), 64'h8001);

    // 5: long zero run, Clear, then a run just short of the threshold
    for (int i = 0; i < ZR + 4; i++) send_word(16'h0000, 16'h0000, 1'b1, -1);
    @(negedge Sclk); Clear = 1'b1;
    @(negedge Sclk); Clear = 1'b0;
    @(negedge Sclk);
    check("after_clear", 64'({in_flag, flag_zeroL, flag_zeroR, dataL, dataR}), 64'd0);
    zl = 0; zr = 0;
    for (int i = 0; i < ZR - 1; i++) send_word(16'h0000, 16'h0000, 1'b1, -1);
    check("flags_after_clear_run", 64'({flag_zeroL, flag_zeroR}), 64'd0);

    // 7: InReady drop mid-word finishes the word; later Frame is ignored
    send_word(16'h1357, 16'h2468, 1'b1, 10);
    send_word(16'hFFFF, 16'hEEEE, 1'b0, -1);
    InReady = 1'b1;
    send_bit(1'b0, 1'b0, 1'b0);
    check("ready_low_hold", 64'({dataL, dataR}), 64'h13572468);

    // 6: back-to-back random words at Sclk/Dclk = 35
    dlow = 170; dhigh = 180;
    for (int i = 0; i < 64; i++) begin
      wl = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
      wr = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
      send_word(wl, wr, 1'b1, -1);
    end
    dlow = 50; dhigh = 50;

    // 8: reset mid-word loses the partial word
    for (int i = 0; i < 8; i++) send_bit(i == 0, 1'b1, 1'b1);
    @(negedge Sclk); Reset_n = 1'b0;
    @(negedge Sclk);
    check("reset_mid_word", 64'({dataL, dataR, in_flag, flag_zeroL, flag_zeroR, frame_err}),
          64'd0);
    Reset_n = 1'b1; zl = 0; zr = 0;
    send_word(16'h1234, 16'h5678, 1'b1, -1);

    repeat (60) @(negedge Sclk);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
